rvc_compress_packer: RTL



---
 rtl/rvc_compress_packer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/rvc_compress_packer.sv
// RVC encoder and little-endian halfword packer.
// Re-encodes a fixed subset of RV32I into 16-bit RVC form. Halfwords are
// packed into 32-bit words, with the earlier instruction in the low half.
// Uncompressible instructions pass through as two halfwords.
module rvc_compress_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_inst,
    output logic        in_ready,
    input  logic        flush,
    output logic        flush_done,
    output logic        out_valid,
    output logic [31:0] out_word,
    input  logic        out_ready,
    output logic [15:0] comp_cnt
);

    logic [6:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        imm6_ok, imm_zero, lw_off_ok, sw_off_ok;
    logic        rd_c, rs1_c, rs2_c;
    logic        is_addi, is_add, is_lw, is_sw;
    logic        comp;
    logic [15:0] enc;

    logic        pend_v, pend_h_unused;
    logic [15:0] pend_h;
    logic        accept, slot_free, flush_ok;
    logic        emit;
    logic [31:0] emit_word;
    logic        nxt_pend_v;
    logic [15:0] nxt_pend_h;

    assign opc = in_inst[6:0];
    assign rd  = in_inst[11:7];
    assign f3  = in_inst[14:12];
    assign rs1 = in_inst[19:15];
    assign rs2 = in_inst[24:20];
    assign f7  = in_inst[31:25];

    // Immediate fits in 6 signed bits when imm[11:5] are all copies of imm[5].
    assign imm6_ok   = (in_inst[31:25] == 7'h00) || (in_inst[31:25] == 7'h7f);
    assign imm_zero  = (in_inst[31:20] == 12'h000);
    // Word-aligned offset in [0,124]: upper bits clear, low two bits clear.
    assign lw_off_ok = (in_inst[31:27] == 5'd0) && (in_inst[21:20] == 2'd0);
    assign sw_off_ok = (in_inst[31:27] == 5'd0) && (in_inst[8:7] == 2'd0);
    assign rd_c  = (rd[4:3] == 2'b01);
    assign rs1_c = (rs1[4:3] == 2'b01);
    assign rs2_c = (rs2[4:3] == 2'b01);

    assign is_addi = (opc == 7'h13) && (f3 == 3'b000);
    assign is_add  = (opc == 7'h33) && (f3 == 3'b000) && (f7 == 7'h00);
    assign is_lw   = (opc == 7'h03) && (f3 == 3'b010);
    assign is_sw   = (opc == 7'h23) && (f3 == 3'b010);

    // Encoder: first matching form wins; anything else is uncompressible.
    always_comb begin
        comp = 1'b0;
        enc  = 16'h0000;
        if (in_inst == 32'h0000_0013) begin
            comp = 1'b1;
            enc  = 16'h0001;
        end else if (is_addi && rd != 5'd0 && rs1 == 5'd0 && imm6_ok) begin
            comp = 1'b1;
            enc  = {3'b010, in_inst[25], rd, in_inst[24:20], 2'b01};
        end else if (is_addi && rd != 5'd0 && rd == rs1 && !imm_zero && imm6_ok) begin
            comp = 1'b1;
            enc  = {3'b000, in_inst[25], rd, in_inst[24:20], 2'b01};
        end else if (is_add && rd != 5'd0 && rs1 == 5'd0 && rs2 != 5'd0) begin
            comp = 1'b1;
            enc  = {4'b1000, rd, rs2, 2'b10};
        end else if (is_add && rd != 5'd0 && rd == rs1 && rs2 != 5'd0) begin
            comp = 1'b1;
            enc  = {4'b1001, rd, rs2, 2'b10};
        end else if (is_lw && rd_c && rs1_c && lw_off_ok) begin
            comp = 1'b1;
            enc  = {3'b010, in_inst[25:23], rs1[2:0], in_inst[22], in_inst[26],
                    rd[2:0], 2'b00};
        end else if (is_sw && rs1_c && rs2_c && sw_off_ok) begin
            comp = 1'b1;
            enc  = {3'b110, in_inst[25], in_inst[11:10], rs1[2:0], in_inst[9],
                    in_inst[26], rs2[2:0], 2'b00};
        end
    end

    assign pend_h_unused = 1'b0;
    assign slot_free = !out_valid || out_ready;
    assign in_ready  = slot_free;
    assign accept    = in_valid && in_ready;
    // An instruction always takes priority over a flush in the same cycle.
    assign flush_ok  = flush && slot_free && !accept;

    // Packer next state: decides what (if anything) is emitted this cycle.
    always_comb begin
        emit       = 1'b0;
        emit_word  = 32'h0000_0000;
        nxt_pend_v = pend_v;
        nxt_pend_h = pend_h;
        if (accept) begin
            if (!pend_v && comp) begin
                nxt_pend_v = 1'b1;
                nxt_pend_h = enc;
            end else if (!pend_v) begin
                emit      = 1'b1;
                emit_word = in_inst;
            end else if (comp) begin
                emit       = 1'b1;
                emit_word  = {enc, pend_h};
                nxt_pend_v = 1'b0;
            end else begin
                emit       = 1'b1;
                emit_word  = {in_inst[15:0], pend_h};
                nxt_pend_h = in_inst[31:16];
            end
        end else if (flush_ok && pend_v) begin
            // Pad the lone halfword with c.nop so the word stays executable.
            emit       = 1'b1;
            emit_word  = {16'h0001, pend_h};
            nxt_pend_v = 1'b0;
        end
    end

    // State and output registers; a held word is only replaced once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v     <= 1'b0;
            pend_h     <= 16'h0000;
            out_valid  <= 1'b0;
            out_word   <= 32'h0000_0000;
            flush_done <= 1'b0;
            comp_cnt   <= 16'h0000;
        end else begin
            pend_v     <= nxt_pend_v;
            pend_h     <= nxt_pend_h;
            flush_done <= flush_ok;
            if (accept && comp) begin
                comp_cnt <= comp_cnt + 16'd1;
            end
            if (emit) begin
                out_valid <= 1'b1;
                out_word  <= emit_word;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
